// File: rtl/ls_gate_pkg.sv
// Shared constants for the 74LS00/02/04 gate bank used on the Pong game-control path.
package ls_gate_pkg;

  localparam int unsigned LS00_GATES     = 4;
  localparam int unsigned LS02_GATES     = 4;
  localparam int unsigned LS04_GATES     = 6;
  localparam int unsigned DLY_STAGES_MAX = 8;

  // Reset values match the gate outputs for all-zero inputs, so idle-low inputs never glitch.
  localparam logic [LS00_GATES-1:0] NAND_RST = 4'hF;
  localparam logic [LS02_GATES-1:0] NOR_RST  = 4'hF;
  localparam logic [LS04_GATES-1:0] INV_RST  = 6'h3F;

endpackage

// File: rtl/ls_gate_bank_if.sv
// Gate-level signal bundle for ls_gate_bank: TTL inputs plus combinational and registered outputs.
interface ls_gate_bank_if;
  import ls_gate_pkg::*;

  logic [LS00_GATES-1:0] nand_a;
  logic [LS00_GATES-1:0] nand_b;
  logic [LS00_GATES-1:0] nand_y;
  logic [LS00_GATES-1:0] nand_q;
  logic [LS02_GATES-1:0] nor_a;
  logic [LS02_GATES-1:0] nor_b;
  logic [LS02_GATES-1:0] nor_y;
  logic [LS02_GATES-1:0] nor_q;
  logic [LS04_GATES-1:0] inv_a;
  logic [LS04_GATES-1:0] inv_y;
  logic [LS04_GATES-1:0] inv_q;

  modport master (
    output nand_a, nand_b, nor_a, nor_b, inv_a,
    input  nand_y, nand_q, nor_y, nor_q, inv_y, inv_q
  );

  modport slave (
    input  nand_a, nand_b, nor_a, nor_b, inv_a,
    output nand_y, nand_q, nor_y, nor_q, inv_y, inv_q
  );

endinterface

// File: rtl/ls_gate_reg_stage.sv
// One register stage of the gate bank output pipeline; async active-high reset to RST_VAL.
module ls_gate_reg_stage #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ls_gate_bank.sv
// 74LS00 + 74LS02 + 74LS04 gate bank with combinational and clk7_159-registered outputs.
// Build option: define LS_GATE_DLY_EN to chain DLY_STAGES register stages on the q outputs.
module ls_gate_bank
  import ls_gate_pkg::*;
#(
  parameter int unsigned DLY_STAGES = 2
) (
  input  logic          clk7_159,
  input  logic          srst,
  ls_gate_bank_if.slave gate
);

`ifdef LS_GATE_DLY_EN
  localparam int unsigned NumStages = DLY_STAGES;

  if (DLY_STAGES < 1 || DLY_STAGES > DLY_STAGES_MAX) begin : g_bad_dly_stages
    $error("ls_gate_bank: DLY_STAGES must be in 1..%0d", DLY_STAGES_MAX);
  end
`else
  localparam int unsigned NumStages = 1;

  // Parameter kept for a uniform interface; the single-stage build does not use it.
  logic [31:0] unused_dly_stages;
  assign unused_dly_stages = DLY_STAGES;
`endif

  // Bitwise gates: each output bit depends only on its own input bits.
  assign gate.nand_y = ~(gate.nand_a & gate.nand_b);
  assign gate.nor_y  = ~(gate.nor_a | gate.nor_b);
  assign gate.inv_y  = ~gate.inv_a;

  logic [LS00_GATES-1:0] nand_pipe [NumStages+1];
  logic [LS02_GATES-1:0] nor_pipe  [NumStages+1];
  logic [LS04_GATES-1:0] inv_pipe  [NumStages+1];

  assign nand_pipe[0] = gate.nand_y;
  assign nor_pipe[0]  = gate.nor_y;
  assign inv_pipe[0]  = gate.inv_y;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    ls_gate_reg_stage #(
      .WIDTH   (LS00_GATES),
      .RST_VAL (NAND_RST)
    ) u_nand_stage (
      .clk_i  (clk7_159),
      .srst_i (srst),
      .d_i    (nand_pipe[s]),
      .q_o    (nand_pipe[s+1])
    );

    ls_gate_reg_stage #(
      .WIDTH   (LS02_GATES),
      .RST_VAL (NOR_RST)
    ) u_nor_stage (
      .clk_i  (clk7_159),
      .srst_i (srst),
      .d_i    (nor_pipe[s]),
      .q_o    (nor_pipe[s+1])
    );

    ls_gate_reg_stage #(
      .WIDTH   (LS04_GATES),
      .RST_VAL (INV_RST)
    ) u_inv_stage (
      .clk_i  (clk7_159),
      .srst_i (srst),
      .d_i    (inv_pipe[s]),
      .q_o    (inv_pipe[s+1])
    );
  end

  assign gate.nand_q = nand_pipe[NumStages];
  assign gate.nor_q  = nor_pipe[NumStages];
  assign gate.inv_q  = inv_pipe[NumStages];

endmodule

// File: tb/tb_ls_gate_bank.sv
// Self-checking bench for ls_gate_bank: directed truth-table/latency/reset steps plus random traffic.
module tb_ls_gate_bank;

`ifdef LS_GATE_DLY_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk7_159 = 1'b0;
  logic srst     = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  ls_gate_bank_if bus ();

  ls_gate_bank #(
    .DLY_STAGES (3)
  ) dut (
    .clk7_159 (clk7_159),
    .srst     (srst),
    .gate     (bus.slave)
  );

  always #5 clk7_159 = ~clk7_159;

  // Reference history: gate values the spec says were captured at each edge since reset.
  logic [3:0] h_nand [$];
  logic [3:0] h_nor  [$];
  logic [5:0] h_inv  [$];

  function automatic logic [3:0] m_nand(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (a[i] == 1'b1 && b[i] == 1'b1) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] m_nor(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (a[i] == 1'b0 && b[i] == 1'b0) ? 1'b1 : 1'b0;
    return r;
  endfunction

  function automatic logic [5:0] m_inv(input logic [5:0] a);
    return 6'd63 - a;
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    h_nand.delete();
    h_nor.delete();
    h_inv.delete();
  endtask

  task automatic chk_q(input string tag);
    if (h_nand.size() >= LAT) begin
      chk({tag, "_nand_q"}, {2'b00, bus.nand_q}, {2'b00, h_nand[LAT-1]});
      chk({tag, "_nor_q"},  {2'b00, bus.nor_q},  {2'b00, h_nor[LAT-1]});
      chk({tag, "_inv_q"},  bus.inv_q,           h_inv[LAT-1]);
    end else begin
      chk({tag, "_nand_q"}, {2'b00, bus.nand_q}, 6'h0F);
      chk({tag, "_nor_q"},  {2'b00, bus.nor_q},  6'h0F);
      chk({tag, "_inv_q"},  bus.inv_q,           6'h3F);
    end
  endtask

  task automatic apply(input logic [3:0] na, input logic [3:0] nb, input logic [3:0] oa,
                       input logic [3:0] ob, input logic [5:0] ia);
    bus.nand_a = na;
    bus.nand_b = nb;
    bus.nor_a  = oa;
    bus.nor_b  = ob;
    bus.inv_a  = ia;
    #1;
    chk("nand_y", {2'b00, bus.nand_y}, {2'b00, m_nand(na, nb)});
    chk("nor_y",  {2'b00, bus.nor_y},  {2'b00, m_nor(oa, ob)});
    chk("inv_y",  bus.inv_y,           m_inv(ia));
  endtask

  // Advance one rising edge, update the reference, then check q outputs 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk7_159);
    if (srst) begin
      model_clear();
    end else begin
      h_nand.push_front(m_nand(bus.nand_a, bus.nand_b));
      h_nor.push_front(m_nor(bus.nor_a, bus.nor_b));
      h_inv.push_front(m_inv(bus.inv_a));
      while (h_nand.size() > LAT) begin
        void'(h_nand.pop_back());
        void'(h_nor.pop_back());
        void'(h_inv.pop_back());
      end
    end
    #1;
    chk_q(tag);
  endtask

  initial begin
    bus.nand_a = '0;
    bus.nand_b = '0;
    bus.nor_a  = '0;
    bus.nor_b  = '0;
    bus.inv_a  = '0;

    // Reset asserted mid-cycle: q forced immediately, comb outputs live.
    #2;
    bus.nand_a = 4'hF;
    bus.nand_b = 4'hF;
    bus.nor_a  = 4'h0;
    bus.inv_a  = 6'h3F;
    srst       = 1'b1;
    #1;
    model_clear();
    chk("rst_nand_q", {2'b00, bus.nand_q}, 6'h0F);
    chk("rst_nor_q",  {2'b00, bus.nor_q},  6'h0F);
    chk("rst_inv_q",  bus.inv_q,           6'h3F);
    chk("rst_nand_y", {2'b00, bus.nand_y}, 6'h00);
    chk("rst_nor_y",  {2'b00, bus.nor_y},  6'h0F);
    chk("rst_inv_y",  bus.inv_y,           6'h00);
    tick("rst_hold");
    tick("rst_hold");

    // Release between edges: q stays at reset until the next edge.
    @(negedge clk7_159);
    srst = 1'b0;
    #1;
    chk_q("rel");

    // Latency: nand 4'hA/4'hC gives 4'h7 combinationally, on q only after LAT edges.
    apply(4'hA, 4'hC, 4'h0, 4'h0, 6'h00);
    chk("lat_nand_y", {2'b00, bus.nand_y}, 6'h07);
    chk("lat_nand_q_before", {2'b00, bus.nand_q}, 6'h0F);
    for (int i = 0; i < LAT; i++) tick("lat");
    chk("lat_nand_q_after", {2'b00, bus.nand_q}, 6'h07);

    // Exhaustive two-input truth tables and all inverter codes.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply(4'(a), 4'(b), 4'(a), 4'(b), 6'(a * 4 + b % 4));
      end
    end
    for (int a = 0; a < 64; a++) apply(4'h0, 4'h0, 4'h0, 4'h0, 6'(a));
    tick("tt_q");

    // Bit independence.
    apply(4'h0, 4'h0, 4'b0001, 4'b0000, 6'h00);
    chk("indep_nor_y", {2'b00, bus.nor_y}, 6'h0E);
    for (int i = 0; i < LAT; i++) tick("indep_flush");
    apply(4'h0, 4'h0, 4'b0001, 4'b0000, 6'h20);
    chk("indep_inv_y", bus.inv_y, 6'h1F);
    for (int i = 0; i < LAT; i++) tick("indep_inv");
    chk("indep_inv_q", bus.inv_q, 6'h1F);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      apply(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 6'($urandom));
      tick("rand");
    end

    // Half-cycle reset pulse mid-stream.
    @(negedge clk7_159);
    srst = 1'b1;
    #1;
    model_clear();
    chk_q("midrst");
    chk("midrst_inv_q", bus.inv_q, 6'h3F);
    #3;
    srst = 1'b0;
    #1;
    chk_q("midrst_rel");
    tick("midrst_edge");
    for (int i = 0; i < 20; i++) begin
      apply(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 6'($urandom));
      tick("post_rst");
    end

    // Step inv_a 00 -> 15: inv_q holds 3F until LAT edges have passed, then reads 2A.
    apply(4'h0, 4'h0, 4'h0, 4'h0, 6'h00);
    for (int i = 0; i < LAT; i++) tick("step_flush");
    apply(4'h0, 4'h0, 4'h0, 4'h0, 6'h15);
    for (int i = 1; i < LAT; i++) begin
      tick("step_hold");
      chk("step_inv_q_hold", bus.inv_q, 6'h3F);
    end
    tick("step_edge");
    chk("step_inv_q", bus.inv_q, 6'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
